// File: rtl/multiplier_five_bits_pkg.sv
// Shared constants and state encoding for the five-bit shift-and-add multiplier.
// Imported by the multiplier top and by the ripple-carry adder.
package multiplier_five_bits_pkg;

  localparam int WIDTH   = 5;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int STEPS   = 5;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

endpackage : multiplier_five_bits_pkg

// File: rtl/multiplier_five_bits_adder.sv
// Five-bit ripple-carry adder; the multiplier's only source of carry into the
// shifted partial product.
module adderFiveBits
  import multiplier_five_bits_pkg::*;
(
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn
);

  logic [WIDTH:0] w_carry;

  // NOTE: every signal written in always_comb gets a value before any branch
  // or loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum        = '0;
    w_carry    = '0;
    w_carry[0] = carryIn;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = A[i] ^ B[i] ^ w_carry[i];
      w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end
  end

  assign carryOut = w_carry[WIDTH];

endmodule : adderFiveBits

// File: rtl/multiplier_five_bits.sv
// Sequential 5x5 unsigned multiplier: one conditional add-and-shift per BUSY
// cycle, a one-cycle DONE pulse, and a product register held until the next start.
module multiplier_five_bits
  import multiplier_five_bits_pkg::*;
#(
  parameter int WIDTH_P = WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH_P-1:0]    A,
  input  logic [WIDTH_P-1:0]    B,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH_P-1:0]  product
);

  mul_state_e        r_state;
  logic [WIDTH-1:0]  r_m;
  logic [WIDTH-1:0]  r_phi;
  logic [WIDTH-1:0]  r_plo;
  logic [CNT_W-1:0]  r_count;
  logic [PROD_W-1:0] r_product;

  mul_state_e        w_state_nxt;
  logic [WIDTH-1:0]  w_m_nxt;
  logic [WIDTH-1:0]  w_phi_nxt;
  logic [WIDTH-1:0]  w_plo_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PROD_W-1:0] w_product_nxt;

  logic [WIDTH-1:0]  w_add_sum;
  logic              w_add_carry;
  logic [WIDTH:0]    w_step_hi;
  logic [PROD_W-1:0] w_shifted;

  adderFiveBits u_adder (
    .sum      (w_add_sum),
    .carryOut (w_add_carry),
    .A        (r_phi),
    .B        (r_m),
    .carryIn  (1'b0)
  );

  // Add M only when the current multiplier LSB is set, then shift {c,s,Plo}
  // right by one; the adder carry becomes the new top bit of Phi.
  assign w_step_hi = r_plo[0] ? {w_add_carry, w_add_sum} : {1'b0, r_phi};
  assign w_shifted = {w_step_hi, r_plo[WIDTH-1:1]};

  always_comb begin
    w_state_nxt   = r_state;
    w_m_nxt       = r_m;
    w_phi_nxt     = r_phi;
    w_plo_nxt     = r_plo;
    w_count_nxt   = r_count;
    w_product_nxt = r_product;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_m_nxt     = A;
          w_plo_nxt   = B;
          w_phi_nxt   = '0;
          w_count_nxt = '0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_phi_nxt   = w_shifted[PROD_W-1:WIDTH];
        w_plo_nxt   = w_shifted[WIDTH-1:0];
        w_count_nxt = CNT_W'(r_count + 1'b1);
        if (r_count == LAST_STEP) begin
          w_product_nxt = w_shifted;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_phi     <= '0;
      r_plo     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_phi     <= w_phi_nxt;
      r_plo     <= w_plo_nxt;
      r_count   <= w_count_nxt;
      r_product <= w_product_nxt;
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule : multiplier_five_bits

// File: tb/tb_multiplier_five_bits.sv
// Self-checking bench for multiplier_five_bits: directed cases, random operands
// scrambled while busy, held start, dropped requests and mid-operation reset.
module tb_multiplier_five_bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] A;
  logic [4:0] B;
  logic       busy;
  logic       done;
  logic [9:0] product;

  int total = 0;
  int bad   = 0;

  multiplier_five_bits dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Operands are presented with start; the accepting edge follows.
  task automatic launch(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Reference: product is the plain integer product of the captured operands,
  // done arrives five edges after acceptance, busy spans six cycles.
  task automatic complete(input logic [4:0] a, input logic [4:0] b,
                          input bit scramble, input string tag);
    int edges;
    int busy_cycles;
    int expected;
    expected = int'(a) * int'(b);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    edges       = 0;
    busy_cycles = 1;
    while (!done && edges < 20) begin
      if (scramble) begin
        A = 5'($urandom);
        B = 5'($urandom);
      end
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cycles++;
    end
    check({tag, "_latency"}, 32'(edges), 32'd5);
    check({tag, "_product"}, 32'(product), 32'(expected));
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd6);
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(expected));
  endtask

  initial begin
    int done_edges[$];
    int seen_done;
    logic [4:0] ra;
    logic [4:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check("reset_outputs", {20'd0, busy, done, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    launch(5'd25, 5'd7);   complete(5'd25, 5'd7,  1'b0, "p25x7");
    launch(5'd31, 5'd31);  complete(5'd31, 5'd31, 1'b0, "p31x31");
    launch(5'd0,  5'd22);  complete(5'd0,  5'd22, 1'b0, "p0x22");

    // A second request during BUSY is dropped.
    launch(5'd2, 5'd2);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    A = 5'd1;
    B = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen_done++;
        check("drop_product", 32'(product), 32'd4);
      end
    end
    check("drop_done_count", 32'(seen_done), 32'd1);
    check("drop_idle", 32'(busy), 32'd0);

    // Random operands, scrambled every cycle after capture.
    for (int n = 0; n < 20; n++) begin
      ra = 5'($urandom);
      rb = 5'($urandom);
      launch(ra, rb);
      complete(ra, rb, 1'b1, "rand");
    end

    // Held start: one result every seven cycles.
    @(negedge clk);
    A     = 5'd3;
    B     = 5'd5;
    start = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_edges.push_back(e);
        check("held_product", 32'(product), 32'd15);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("held_pulses", 32'(done_edges.size()), 32'd4);
    for (int i = 1; i < done_edges.size(); i++)
      check("held_period", 32'(done_edges[i] - done_edges[i-1]), 32'd7);
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    check("held_idle", 32'(busy), 32'd0);

    // Asynchronous reset at BUSY step 3 aborts without done.
    launch(5'd9, 5'd9);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {20'd0, busy, done, product}, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("reset_no_done", 32'(seen_done), 32'd0);

    // Start presented with reset release is taken on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    A     = 5'd16;
    B     = 5'd3;
    start = 1'b1;
    complete(5'd16, 5'd3, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_multiplier_five_bits
